// File: rtl/pulse_sequence_checker.sv
// rtl/pulse_sequence_checker.sv - pulse encoder feeding a four-code unlock sequence FSM with error lockout and timeout
module pulse_sequence_checker #(
    parameter int SEQ0    = 5,
    parameter int SEQ1    = 4,
    parameter int SEQ2    = 3,
    parameter int SEQ3    = 2,
    parameter int MAX_ERR = 3,
    parameter int TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Input_D,
    input  logic       Clear,
    output logic [2:0] Code,
    output logic       Valid,
    output logic       Multi,
    output logic       Unlock,
    output logic       Error,
    output logic [1:0] ErrCnt
);

    localparam logic [2:0] SEQ0_C    = SEQ0[2:0];
    localparam logic [2:0] SEQ1_C    = SEQ1[2:0];
    localparam logic [2:0] SEQ2_C    = SEQ2[2:0];
    localparam logic [2:0] SEQ3_C    = SEQ3[2:0];
    localparam logic [1:0] MAX_ERR_C = MAX_ERR[1:0];
    localparam logic [3:0] TIMEOUT_C = TIMEOUT[3:0];

    typedef enum logic [2:0] {IDLE, M1, M2, M3, OPEN, LOCK} state_t;

    state_t     state, state_nxt;
    logic [1:0] err_nxt, err_inc;
    logic [3:0] tmo, tmo_nxt;
    logic [2:0] exp_code, enc_code;
    logic       enc_any, enc_multi;

    // Bit 0 only ever encodes 0 and is overridden by any higher bit; it never raises Valid.
    always_comb begin
        enc_code = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (Input_D[i]) enc_code = 3'(i);
        end
        enc_any   = |Input_D[5:1];
        enc_multi = (Input_D[5:1] & (Input_D[5:1] - 5'd1)) != 5'd0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Code  <= 3'd0;
            Valid <= 1'b0;
            Multi <= 1'b0;
        end else begin
            Valid <= enc_any;
            Multi <= enc_any & enc_multi;
            if (enc_any) Code <= enc_code;
        end
    end

    always_comb begin
        case (state)
            M1:      exp_code = SEQ1_C;
            M2:      exp_code = SEQ2_C;
            M3:      exp_code = SEQ3_C;
            default: exp_code = SEQ0_C;
        endcase
        err_inc   = (ErrCnt == 2'b11) ? ErrCnt : ErrCnt + 2'd1;
        state_nxt = state;
        err_nxt   = ErrCnt;
        tmo_nxt   = tmo;
        if (Clear) begin
            state_nxt = IDLE;
            err_nxt   = 2'd0;
            tmo_nxt   = 4'd0;
        end else if (state != OPEN && state != LOCK) begin
            if (Valid) begin
                tmo_nxt = 4'd0;
                if (Code == exp_code) begin
                    case (state)
                        IDLE:    state_nxt = M1;
                        M1:      state_nxt = M2;
                        M2:      state_nxt = M3;
                        default: begin
                            state_nxt = OPEN;
                            err_nxt   = 2'd0;
                        end
                    endcase
                end else begin
                    err_nxt = err_inc;
                    // Reaching the error limit wins over the restart target.
                    if (err_inc == MAX_ERR_C)  state_nxt = LOCK;
                    else if (Code == SEQ0_C)   state_nxt = M1;
                    else                       state_nxt = IDLE;
                end
            end else if (state != IDLE) begin
                if (tmo == TIMEOUT_C) begin
                    state_nxt = IDLE;
                    tmo_nxt   = 4'd0;
                end else begin
                    tmo_nxt = tmo + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            ErrCnt <= 2'd0;
            tmo    <= 4'd0;
            Unlock <= 1'b0;
            Error  <= 1'b0;
        end else begin
            state  <= state_nxt;
            ErrCnt <= err_nxt;
            tmo    <= tmo_nxt;
            Unlock <= (state_nxt == OPEN);
            Error  <= (state_nxt == LOCK);
        end
    end

endmodule

// File: tb/tb_pulse_sequence_checker.sv
// tb/tb_pulse_sequence_checker.sv - directed and randomized check of pulse_sequence_checker against a reference model
module tb_pulse_sequence_checker;

    localparam int MAX_ERR = 3;
    localparam int TIMEOUT = 15;

    logic       CLK = 1'b0;
    logic       RST, Clear;
    logic [5:0] Input_D;
    logic [2:0] Code;
    logic       Valid, Multi, Unlock, Error;
    logic [1:0] ErrCnt;

    pulse_sequence_checker dut (
        .CLK(CLK), .RST(RST), .Input_D(Input_D), .Clear(Clear),
        .Code(Code), .Valid(Valid), .Multi(Multi),
        .Unlock(Unlock), .Error(Error), .ErrCnt(ErrCnt)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int seq [4] = '{5, 4, 3, 2};

    // Model: matched = how many sequence codes are already accepted.
    int m_code = 0, m_valid = 0, m_multi = 0;
    int matched = 0, is_open = 0, is_lock = 0, errs = 0, idle = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_update(input logic [5:0] d, input logic clr, input logic rst);
        int hi, ones;
        if (rst) begin
            m_code = 0; m_valid = 0; m_multi = 0;
            matched = 0; is_open = 0; is_lock = 0; errs = 0; idle = 0;
            return;
        end
        if (clr) begin
            matched = 0; is_open = 0; is_lock = 0; errs = 0; idle = 0;
        end else if (!is_open && !is_lock) begin
            if (m_valid != 0) begin
                idle = 0;
                if (m_code == seq[matched]) begin
                    matched++;
                    if (matched == 4) begin
                        is_open = 1; matched = 0; errs = 0;
                    end
                end else begin
                    errs = (errs < 3) ? errs + 1 : 3;
                    if (errs == MAX_ERR) begin
                        is_lock = 1; matched = 0;
                    end else begin
                        matched = (m_code == seq[0]) ? 1 : 0;
                    end
                end
            end else if (matched > 0) begin
                if (idle == TIMEOUT) begin
                    matched = 0; idle = 0;
                end else begin
                    idle++;
                end
            end
        end
        hi = 0; ones = 0;
        for (int i = 1; i < 6; i++) begin
            if (d[i]) begin
                hi = i; ones++;
            end
        end
        if (ones > 0) begin
            m_code = hi; m_valid = 1; m_multi = (ones > 1) ? 1 : 0;
        end else begin
            m_valid = 0; m_multi = 0;
        end
    endtask

    task automatic step(input logic [5:0] d, input logic clr, input logic rst);
        Input_D = d; Clear = clr; RST = rst;
        @(posedge CLK);
        model_update(d, clr, rst);
        #1;
        check("Code",   32'(Code),   32'(m_code));
        check("Valid",  32'(Valid),  32'(m_valid));
        check("Multi",  32'(Multi),  32'(m_multi));
        check("Unlock", 32'(Unlock), 32'(is_open));
        check("Error",  32'(Error),  32'(is_lock));
        check("ErrCnt", 32'(ErrCnt), 32'(errs));
    endtask

    task automatic pulse(input int c);
        logic [5:0] d;
        d = 6'd0;
        d[c] = 1'b1;
        step(d, 1'b0, 1'b0);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(6'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int ptr = 0;
        int r;
        logic [5:0] d;

        step(6'd0, 1'b0, 1'b1);
        step(6'd0, 1'b1, 1'b1);
        check("reset_errcnt", 32'(ErrCnt), 32'd0);

        pulse(5); pulse(4); pulse(3); pulse(2);
        pulse(1);
        check("seq_unlock", 32'(Unlock), 32'd1);
        check("seq_errcnt", 32'(ErrCnt), 32'd0);
        idles(2);
        check("open_hold", 32'(Unlock), 32'd1);
        step(6'd0, 1'b1, 1'b0);

        step(6'b101000, 1'b0, 1'b0);
        check("multi_code", 32'(Code), 32'd5);
        check("multi_flag", 32'(Multi), 32'd1);
        idles(1);
        step(6'd0, 1'b1, 1'b0);

        pulse(1); idles(1);
        check("err1", 32'(ErrCnt), 32'd1);
        pulse(1); idles(1);
        check("err2", 32'(ErrCnt), 32'd2);
        pulse(1); idles(1);
        check("err3_lock", 32'(Error), 32'd1);
        pulse(5); pulse(4); pulse(3); pulse(2); idles(2);
        check("lock_no_unlock", 32'(Unlock), 32'd0);
        step(6'd0, 1'b1, 1'b0);

        pulse(5); idles(16); pulse(4); idles(2);
        check("timeout_err", 32'(ErrCnt), 32'd1);
        step(6'd0, 1'b1, 1'b0);

        pulse(5); pulse(4); pulse(3); pulse(2);
        step(6'd0, 1'b1, 1'b0);
        idles(1);
        check("clear_beats_valid", 32'(Unlock), 32'd0);

        pulse(5); pulse(4); idles(1);
        step(6'd0, 1'b0, 1'b1);
        check("rst_mid_unlock", 32'(Unlock), 32'd0);
        pulse(5); pulse(4); pulse(3); pulse(2); idles(1);
        check("rst_then_open", 32'(Unlock), 32'd1);
        step(6'd0, 1'b1, 1'b0);

        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(6'd0, 1'b0, 1'b1);
            end else if (r < 5) begin
                step(6'($urandom), 1'b1, 1'b0);
            end else if (r < 7) begin
                idles(TIMEOUT + $urandom_range(0, 3));
            end else if (r < 40) begin
                d = 6'd0;
                if ($urandom_range(0, 9) < 8) begin
                    d[seq[ptr]] = 1'b1;
                    ptr = (ptr + 1) % 4;
                end else begin
                    d[$urandom_range(1, 5)] = 1'b1;
                end
                d[0] = 1'($urandom);
                step(d, 1'b0, 1'b0);
            end else if (r < 45) begin
                step(6'($urandom), 1'b0, 1'b0);
            end else begin
                step({5'd0, 1'($urandom)}, 1'b0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
